// File: rtl/vsm_mem_arbiter.sv
// vsm_mem_arbiter: two-port (fetch / data) sequencer for the VSM 8x4 memory.
// Serialises requests and wraps each access in setup / strobe / hold phases so
// MemAddr and Mem_In are stable around every ReadMem / WriteMem pulse.
// Build option: define VSM_ARB_FIXED_PRIO_EN for fixed fetch-over-data priority;
// left undefined, contention is resolved round-robin.
module vsm_mem_arbiter #(
  parameter int ADDR_W     = 3,
  parameter int DATA_W     = 4,
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 1
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              FetchReq,
  input  logic [ADDR_W-1:0] FetchAddr,
  output logic              FetchAck,
  output logic [DATA_W-1:0] FetchData,
  input  logic              DataReq,
  input  logic              DataWe,
  input  logic [ADDR_W-1:0] DataAddr,
  input  logic [DATA_W-1:0] DataWdata,
  output logic              DataAck,
  output logic [DATA_W-1:0] DataRdata,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] Mem_In,
  output logic              ReadMem,
  output logic              WriteMem,
  input  logic [DATA_W-1:0] MemOut,
  output logic              Busy
);
  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, STROBE = 2'd2, HOLD = 2'd3} state_t;

  localparam logic [1:0] SETUP_LD  = 2'(SETUP_CYC - 1);
  localparam logic [1:0] STROBE_LD = 2'(STROBE_CYC - 1);

  state_t     state, state_nxt;
  logic [1:0] cnt, cnt_nxt;
  logic       gap;        // first IDLE cycle after HOLD: requests are not arbitrated
  logic       cur_fetch;  // granted port of the transaction in flight
  logic       cur_we;
  logic       grant;
  logic       gnt_fetch;

`ifdef VSM_ARB_FIXED_PRIO_EN
  // Fetch always wins; data is served only when fetch is not requesting
  assign gnt_fetch = FetchReq;
`else
  logic last_fetch;       // 1 = last grant went to fetch, 0 = data
  // On contention the port that was not granted last time wins
  assign gnt_fetch = FetchReq && (!DataReq || !last_fetch);

  // Remember the last winner for round-robin
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)     last_fetch <= 1'b0;
    else if (grant) last_fetch <= gnt_fetch;
  end
`endif

  // Next-state and phase counter
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    grant     = 1'b0;
    case (state)
      IDLE: if (!gap && (FetchReq || DataReq)) begin
        grant     = 1'b1;
        state_nxt = SETUP;
        cnt_nxt   = SETUP_LD;
      end
      SETUP: if (cnt == 2'd0) begin
        state_nxt = STROBE;
        cnt_nxt   = STROBE_LD;
      end else cnt_nxt = cnt - 2'd1;
      STROBE: if (cnt == 2'd0) state_nxt = HOLD;
              else cnt_nxt = cnt - 2'd1;
      HOLD:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register and operand capture at grant; MemAddr/Mem_In move only here
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state     <= IDLE;
      cnt       <= 2'd0;
      gap       <= 1'b0;
      cur_fetch <= 1'b0;
      cur_we    <= 1'b0;
      MemAddr   <= '0;
      Mem_In    <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      gap   <= (state == HOLD);
      if (grant) begin
        cur_fetch <= gnt_fetch;
        cur_we    <= !gnt_fetch && DataWe;
        MemAddr   <= gnt_fetch ? FetchAddr : DataAddr;
        Mem_In    <= (!gnt_fetch && DataWe) ? DataWdata : '0;
      end
    end
  end

  // Registered strobes, acks, busy and read-data capture, decoded from the next state
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      ReadMem   <= 1'b0;
      WriteMem  <= 1'b0;
      FetchAck  <= 1'b0;
      DataAck   <= 1'b0;
      Busy      <= 1'b0;
      FetchData <= '0;
      DataRdata <= '0;
    end else begin
      ReadMem  <= (state_nxt == STROBE) && !cur_we;
      WriteMem <= (state_nxt == STROBE) &&  cur_we;
      FetchAck <= (state_nxt == HOLD) &&  cur_fetch;
      DataAck  <= (state_nxt == HOLD) && !cur_fetch;
      Busy     <= (state_nxt != IDLE);
      if (state == STROBE && state_nxt == HOLD && !cur_we) begin
        if (cur_fetch) FetchData <= MemOut;
        else           DataRdata <= MemOut;
      end
    end
  end
endmodule

// File: tb/tb_vsm_mem_arbiter.sv
// tb_vsm_mem_arbiter: randomized two-port traffic against a transaction-level
// model (grant order, completion cycle, memory contents); a negedge monitor
// pops expected acks and strobes from queues and compares.
module tb_vsm_mem_arbiter;
  localparam int AW  = 3;
  localparam int DW  = 4;
  localparam int SC  = 1;
  localparam int ST  = 1;
  localparam int LAT = SC + ST + 1;  // grant cycle -> ack cycle
  localparam int GAP = SC + ST + 3;  // grant cycle -> next possible grant

  logic          Clk, Rst_n;
  logic          FetchReq, FetchAck, DataReq, DataWe, DataAck;
  logic [AW-1:0] FetchAddr, DataAddr, MemAddr;
  logic [DW-1:0] FetchData, DataWdata, DataRdata, Mem_In, MemOut;
  logic          ReadMem, WriteMem, Busy;

  vsm_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .SETUP_CYC(SC), .STROBE_CYC(ST)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .FetchReq(FetchReq), .FetchAddr(FetchAddr), .FetchAck(FetchAck), .FetchData(FetchData),
    .DataReq(DataReq), .DataWe(DataWe), .DataAddr(DataAddr), .DataWdata(DataWdata),
    .DataAck(DataAck), .DataRdata(DataRdata),
    .MemAddr(MemAddr), .Mem_In(Mem_In), .ReadMem(ReadMem), .WriteMem(WriteMem),
    .MemOut(MemOut), .Busy(Busy));

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // Memory environment
  logic [DW-1:0] mem [8];
  logic [DW-1:0] init_v [8];
  logic          load;
  assign MemOut = mem[MemAddr];
  always @(posedge Clk) begin
    if (load) for (int i = 0; i < 8; i++) mem[i] <= init_v[i];
    else if (WriteMem) mem[MemAddr] <= Mem_In;
  end

  typedef struct {
    int          cyc;
    logic        we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  exp_t fq[$], dq[$], sq[$];
  int   tests = 0, fails = 0;

  // Reference model state
  logic [DW-1:0] ref_mem [8];
  bit   f_pend, f_wait, d_pend, d_wait, last_fetch, mon_en;
  int   f_ack, d_ack, free_at, busy_lo, busy_hi;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model of one arbitration opportunity
  task automatic arbitrate();
    bit   pick_f;
    exp_t e, s;
    if (cyc >= free_at && (f_pend || d_pend)) begin
`ifdef VSM_ARB_FIXED_PRIO_EN
      pick_f = f_pend;
`else
      if (f_pend && d_pend) pick_f = !last_fetch;
      else                  pick_f = f_pend;
`endif
      last_fetch = pick_f;
      e.cyc = cyc + LAT;
      if (pick_f) begin
        e.we = 1'b0; e.addr = FetchAddr; e.data = ref_mem[FetchAddr];
        fq.push_back(e);
        f_pend = 0; f_wait = 1; f_ack = cyc + LAT;
      end else begin
        e.we = DataWe; e.addr = DataAddr;
        if (DataWe) begin
          ref_mem[DataAddr] = DataWdata;
          e.data = DataWdata;
        end else e.data = ref_mem[DataAddr];
        dq.push_back(e);
        d_pend = 0; d_wait = 1; d_ack = cyc + LAT;
      end
      s = e;
      s.cyc = cyc + SC + 1;
      if (!e.we) s.data = '0;
      sq.push_back(s);
      busy_lo = cyc + 1;
      busy_hi = cyc + LAT;
      free_at = cyc + GAP;
    end
  endtask

  task automatic step(input int p_new, input int p_drop);
    @(posedge Clk); #1;
    if (f_wait && cyc >= f_ack) begin f_wait = 0; FetchReq = 0; end
    if (d_wait && cyc >= d_ack) begin d_wait = 0; DataReq = 0; end
    if (!f_pend && !f_wait && int'($urandom_range(99)) < p_new) begin
      FetchReq = 1; FetchAddr = AW'($urandom); f_pend = 1;
    end
    if (!d_pend && !d_wait && int'($urandom_range(99)) < p_new) begin
      DataReq = 1; DataWe = 1'($urandom); DataAddr = AW'($urandom);
      DataWdata = DW'($urandom); d_pend = 1;
    end
    if (f_wait && int'($urandom_range(99)) < p_drop) begin
      FetchReq = 0; FetchAddr = AW'($urandom);
    end
    if (d_wait && int'($urandom_range(99)) < p_drop) begin
      DataReq = 0; DataWe = 1'($urandom); DataAddr = AW'($urandom); DataWdata = DW'($urandom);
    end
    arbitrate();
  endtask

  task automatic drain();
    bit idle;
    idle = 0;
    for (int n = 0; n < 200 && !idle; n++) begin
      step(0, 0);
      idle = !f_pend && !f_wait && !d_pend && !d_wait && cyc >= free_at;
    end
    chk("drain_idle", idle, 1);
  endtask

  task automatic do_data(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] w);
    drain();
    DataReq = 1; DataWe = we; DataAddr = a; DataWdata = w; d_pend = 1;
    arbitrate();
    drain();
  endtask

  task automatic do_fetch(input logic [AW-1:0] a);
    drain();
    FetchReq = 1; FetchAddr = a; f_pend = 1;
    arbitrate();
    drain();
  endtask

  // Monitor: scoreboard pops on acks and strobe starts, plus per-cycle invariants
  bit   in_strb;
  int   strb_len, last_chg;
  logic [AW+DW-1:0] prev_mem;
  logic [DW-1:0] exp_fdata, exp_drdata;
  exp_t cs, me;

  always @(negedge Clk) begin
    if (!mon_en) begin
      in_strb = 0; strb_len = 0; exp_fdata = '0; exp_drdata = '0;
      prev_mem = {MemAddr, Mem_In}; last_chg = cyc;
    end else begin
      if ({MemAddr, Mem_In} != prev_mem) last_chg = cyc;
      prev_mem = {MemAddr, Mem_In};
      chk("busy", Busy, int'(cyc >= busy_lo && cyc <= busy_hi));
      chk("strobe_excl", int'(ReadMem && WriteMem), 0);
      chk("ack_excl", int'(FetchAck && DataAck), 0);
      if (ReadMem || WriteMem) begin
        if (!in_strb) begin
          chk("strobe_expected", int'(sq.size() != 0), 1);
          if (sq.size() != 0) begin
            cs = sq.pop_front();
            chk("strobe_cycle", cyc, cs.cyc);
            chk("strobe_write", WriteMem, cs.we);
            chk("strobe_read", ReadMem, !cs.we);
            chk("strobe_memin", Mem_In, cs.data);
            chk("setup_stable", int'(cyc - last_chg >= SC), 1);
          end
          in_strb = 1; strb_len = 0;
        end
        strb_len++;
        chk("strobe_addr", MemAddr, cs.addr);
      end else if (in_strb) begin
        in_strb = 0;
        chk("strobe_len", strb_len, ST);
      end
      if (FetchAck) begin
        chk("fetch_ack_expected", int'(fq.size() != 0), 1);
        if (fq.size() != 0) begin
          me = fq.pop_front();
          chk("fetch_ack_cycle", cyc, me.cyc);
          chk("fetch_data", FetchData, me.data);
          chk("fetch_hold_addr", MemAddr, me.addr);
          exp_fdata = me.data;
        end
      end else chk("fetch_data_held", FetchData, exp_fdata);
      if (DataAck) begin
        chk("data_ack_expected", int'(dq.size() != 0), 1);
        if (dq.size() != 0) begin
          me = dq.pop_front();
          chk("data_ack_cycle", cyc, me.cyc);
          chk("data_hold_addr", MemAddr, me.addr);
          if (!me.we) exp_drdata = me.data;
          chk("data_rdata", DataRdata, exp_drdata);
        end
      end else chk("data_rdata_held", DataRdata, exp_drdata);
    end
  end

  logic [DW-1:0] old;

  initial begin
    Rst_n = 0; load = 1; mon_en = 0;
    FetchReq = 0; FetchAddr = '0; DataReq = 0; DataWe = 0; DataAddr = '0; DataWdata = '0;
    f_pend = 0; f_wait = 0; d_pend = 0; d_wait = 0; last_fetch = 0;
    f_ack = 0; d_ack = 0; free_at = 0; busy_lo = 1; busy_hi = 0;
    for (int i = 0; i < 8; i++) begin
      init_v[i] = DW'($urandom);
      ref_mem[i] = init_v[i];
    end
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_busy", Busy, 0);
    chk("rst_readmem", ReadMem, 0);
    chk("rst_writemem", WriteMem, 0);
    chk("rst_fetchack", FetchAck, 0);
    chk("rst_dataack", DataAck, 0);
    chk("rst_memaddr", MemAddr, 0);
    chk("rst_memin", Mem_In, 0);
    chk("rst_fetchdata", FetchData, 0);
    chk("rst_datardata", DataRdata, 0);
    load = 0; Rst_n = 1; free_at = cyc; mon_en = 1;

    // Directed: write then read back, then fetch-data hold across a data write
    do_data(1'b1, 3'd5, 4'hA);
    do_data(1'b0, 3'd5, 4'h0);
    do_data(1'b1, 3'd3, 4'h7);
    do_fetch(3'd3);
    do_data(1'b1, 3'd6, 4'h2);

    // Random traffic with request drops, then saturation (both ports always requesting)
    for (int n = 0; n < 3000; n++) step(60, 20);
    for (int n = 0; n < 200; n++) step(100, 0);
    drain();

    // Reset in the middle of a write strobe
    old = ref_mem[4];
    DataReq = 1; DataWe = 1; DataAddr = 3'd4; DataWdata = ~old; d_pend = 1;
    arbitrate();
    for (int n = 0; n < SC + 1; n++) step(0, 0);
    #2;
    chk("pre_rst_writemem", WriteMem, 1);
    mon_en = 0; Rst_n = 0;
    #1;
    chk("async_rst_writemem", WriteMem, 0);
    chk("async_rst_busy", Busy, 0);
    chk("async_rst_dataack", DataAck, 0);
    fq.delete(); dq.delete(); sq.delete();
    ref_mem[4] = old;
    DataReq = 0; d_pend = 0; d_wait = 0; last_fetch = 0; busy_lo = 1; busy_hi = 0;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst2_dataack", DataAck, 0);
    chk("rst2_memaddr", MemAddr, 0);
    Rst_n = 1; free_at = cyc; mon_en = 1;
    step(0, 0);
    chk("post_rst_idle", Busy, 0);
    do_fetch(3'd4);
    for (int n = 0; n < 500; n++) step(60, 20);
    drain();

    chk("fetch_queue_empty", fq.size(), 0);
    chk("data_queue_empty", dq.size(), 0);
    chk("strobe_queue_empty", sq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
